// File: rtl/irq_ack_ctrl.sv
// Level interrupt generator: queues single-cycle events in a saturating counter and holds
// irq_out high until acknowledged, then forces a fixed low gap before re-asserting.
module irq_ack_ctrl #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irq_pulse_in,
  input  logic             irq_enable,
  input  logic             irq_ack,
  input  logic             clear_overflow,
  output logic             irq_out,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [7:0]       GapLoad = 8'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             irq_q;

  logic accept, valid_ack, saturate;

  assign accept    = irq_pulse_in & irq_enable;
  assign valid_ack = irq_ack & (state_q == StAssert);
  assign saturate  = accept & ~valid_ack & (cnt_q == CntMax);

  // A simultaneous accepted event and valid acknowledge cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !valid_ack && !saturate) begin
      cnt_d = cnt_q + 1'b1;
    end else if (valid_ack && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (saturate)       ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0 && irq_enable) state_d = StAssert;
      end
      StAssert: begin
        if (irq_ack) begin
          state_d = StGap;
          gap_d   = GapLoad;
        end else if (!irq_enable) begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == 8'd0) begin
          state_d = (cnt_q != '0 && irq_enable) ? StAssert : StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= 8'd0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      irq_q   <= (state_d == StAssert);
    end
  end

  assign irq_out       = irq_q;
  assign pending_count = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Bench for irq_ack_ctrl: a cycle model pushes expected outputs into a scoreboard queue as
// each stimulus cycle is driven; entries are popped and compared after the clock edge.
module tb_irq_ack_ctrl;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned MAXC       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             irq_pulse_in, irq_enable, irq_ack, clear_overflow;
  logic             irq_out;
  logic [CNT_W-1:0] pending_count;
  logic             overflow;

  irq_ack_ctrl #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_pulse_in   (irq_pulse_in),
    .irq_enable     (irq_enable),
    .irq_ack        (irq_ack),
    .clear_overflow (clear_overflow),
    .irq_out        (irq_out),
    .pending_count  (pending_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        irq;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = asserted, 2 = gap
  int m_st, m_cnt, m_gap;
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_gap = 0; m_ovf = 1'b0;
  endtask

  task automatic step(input string tag, input bit p, input bit en, input bit a, input bit c);
    bit   valid, acc;
    int   ncnt, nst;
    exp_t e, o;
    @(negedge clk);
    irq_pulse_in = p; irq_enable = en; irq_ack = a; clear_overflow = c;
    valid = a && (m_st == 1);
    acc   = p && en;
    ncnt  = m_cnt;
    if (c) m_ovf = 1'b0;
    if (acc && !valid) begin
      if (m_cnt == MAXC) m_ovf = 1'b1;
      else ncnt = m_cnt + 1;
    end else if (valid && !acc) begin
      ncnt = m_cnt - 1;
    end
    nst = m_st;
    case (m_st)
      0: if (m_cnt > 0 && en) nst = 1;
      1: if (a) begin nst = 2; m_gap = GAP_CYCLES - 1; end
         else if (!en) nst = 0;
      default: if (m_gap == 0) nst = (m_cnt > 0 && en) ? 1 : 0;
               else m_gap--;
    endcase
    m_st  = nst;
    m_cnt = ncnt;
    e.irq = (nst == 1);
    e.cnt = 32'(ncnt);
    e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_eq({tag, "_irq"}, 32'(irq_out), 32'(o.irq));
    check_eq({tag, "_cnt"}, 32'(pending_count), o.cnt);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(o.ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    irq_pulse_in = 1'b0; irq_enable = 1'b0; irq_ack = 1'b0; clear_overflow = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int  lows;
  int  rises;
  bit  found;

  initial begin
    rst_n = 1'b0;
    irq_pulse_in = 1'b0; irq_enable = 1'b0; irq_ack = 1'b0; clear_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_irq", 32'(irq_out), 32'd0);
    check_eq("rst_cnt", 32'(pending_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single event
    repeat (3) step("idle", 0, 1, 0, 0);
    step("pulse", 1, 1, 0, 0);
    check_eq("single_cnt1", 32'(pending_count), 32'd1);
    check_eq("single_irq_late", 32'(irq_out), 32'd0);
    step("rise", 0, 1, 0, 0);
    check_eq("single_irq_up", 32'(irq_out), 32'd1);
    repeat (5) step("hold", 0, 1, 0, 0);
    step("ack", 0, 1, 1, 0);
    check_eq("single_ack_irq", 32'(irq_out), 32'd0);
    check_eq("single_ack_cnt", 32'(pending_count), 32'd0);
    repeat (6) step("post", 0, 1, 0, 0);

    // Burst of three, each acknowledged two cycles after irq_out rises
    repeat (3) step("burst_in", 1, 1, 0, 0);
    rises = 0;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      lows  = (k == 0) ? 0 : 1;
      for (int t = 0; t < 20 && !found; t++) begin
        step("burst_wait", 0, 1, 0, 0);
        if (irq_out) found = 1'b1;
        else lows++;
      end
      check_eq("burst_found", 32'(found), 32'd1);
      if (found) rises++;
      if (k > 0) check_eq("burst_gap_len", 32'(lows), 32'(GAP_CYCLES));
      step("burst_hold", 0, 1, 0, 0);
      step("burst_ack", 0, 1, 1, 0);
      check_eq("burst_cnt", 32'(pending_count), 32'(2 - k));
    end
    repeat (8) step("burst_tail", 0, 1, 0, 0);
    check_eq("burst_rises", 32'(rises), 32'd3);
    check_eq("burst_final_irq", 32'(irq_out), 32'd0);

    // Saturation and overflow
    for (int i = 0; i < 16; i++) step("sat_in", 1, 1, 0, 0);
    check_eq("sat_cnt", 32'(pending_count), 32'(MAXC));
    check_eq("sat_ovf", 32'(overflow), 32'd1);
    step("sat_setwins", 1, 1, 0, 1);
    check_eq("sat_setwins_ovf", 32'(overflow), 32'd1);
    step("sat_clr", 0, 1, 0, 1);
    check_eq("sat_clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous pulse and ack at full count
    step("simul", 1, 1, 1, 0);
    check_eq("simul_cnt", 32'(pending_count), 32'(MAXC));
    check_eq("simul_ovf", 32'(overflow), 32'd0);
    check_eq("simul_irq", 32'(irq_out), 32'd0);

    // Enable gating and ignored acks
    do_reset();
    step("dis_pulse", 1, 0, 0, 0);
    step("dis_pulse", 1, 0, 0, 0);
    check_eq("dis_cnt", 32'(pending_count), 32'd0);
    step("en_pulse", 1, 1, 0, 0);
    step("en_pulse", 1, 1, 0, 0);
    step("en_up", 0, 1, 0, 0);
    check_eq("en_irq", 32'(irq_out), 32'd1);
    step("drop_en", 0, 0, 0, 0);
    check_eq("drop_irq", 32'(irq_out), 32'd0);
    check_eq("drop_cnt", 32'(pending_count), 32'd2);
    step("ack_idle", 0, 0, 1, 0);
    check_eq("ack_idle_cnt", 32'(pending_count), 32'd2);
    step("reen", 0, 1, 0, 0);
    check_eq("reen_irq", 32'(irq_out), 32'd1);
    step("ack_a", 0, 1, 1, 0);
    step("ack_gap", 0, 1, 1, 0);
    check_eq("ack_gap_cnt", 32'(pending_count), 32'd1);
    repeat (6) step("gap_tail", 0, 1, 0, 0);

    // Asynchronous reset in the middle of a gap
    do_reset();
    repeat (6) step("ar_in", 1, 1, 0, 0);
    step("ar_hold", 0, 1, 0, 0);
    step("ar_ack", 0, 1, 1, 0);
    step("ar_gap", 0, 1, 0, 0);
    check_eq("ar_pre_cnt", 32'(pending_count), 32'd5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("ar_irq", 32'(irq_out), 32'd0);
    check_eq("ar_cnt", 32'(pending_count), 32'd0);
    check_eq("ar_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step("ar_quiet", 0, 1, 0, 0);
    check_eq("ar_quiet_irq", 32'(irq_out), 32'd0);
    step("ar_new", 1, 1, 0, 0);
    step("ar_new_up", 0, 1, 0, 0);
    check_eq("ar_new_irq", 32'(irq_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
